// File: rtl/subtractor_serial_8bit.sv
// Bit-serial subtractor: diff = min - sub - preB, one bit per clock, LSB first, with a start/done handshake.
// Latency: done and the result appear WIDTH cycles after the accepting edge; busy is high for WIDTH+1 cycles.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy.
module subtractor_serial_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] sub,
    input  logic             preB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             proB
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             prob_q, prob_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_bit;
    logic             brw_nxt;

    always_comb begin
        d_bit   = opa_q[0] ^ opb_q[0] ^ brw_q;
        brw_nxt = (~opa_q[0] & opb_q[0]) | (~opa_q[0] & brw_q) | (opb_q[0] & brw_q);

        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        brw_d   = brw_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        prob_d  = prob_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = min;
                    opb_d   = sub;
                    brw_d   = preB;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                brw_d = brw_nxt;
                // New bit enters at the MSB so the LSB-first stream lands in order.
                res_d = {d_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = res_d;
                    prob_d  = brw_nxt;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            prob_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            prob_q  <= prob_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign proB = prob_q;

endmodule

// File: tb/tb_subtractor_serial_8bit.sv
// Bench for subtractor_serial_8bit: directed vectors, protocol checks and a random sweep
// against an arithmetic reference of min - sub - preB.
module tb_subtractor_serial_8bit;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] min;
    logic [7:0] sub;
    logic       preB;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       proB;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_diff;
    logic       exp_prob;

    subtractor_serial_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .min   (min),
        .sub   (sub),
        .preB  (preB),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .proB  (proB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference: (WIDTH+1)-bit unsigned difference; top bit is the borrow-out.
    function automatic logic [8:0] ref_sub(input logic [7:0] m, input logic [7:0] s, input logic b);
        return {1'b0, m} - {1'b0, s} - {8'd0, b};
    endfunction

    // Issues one operation from IDLE and checks latency, hold-while-busy, result and done pulse.
    task automatic run_op(input logic [7:0] m, input logic [7:0] s, input logic b, input bit noisy);
        logic [8:0] r;
        int lat;
        r = ref_sub(m, s, b);
        @(negedge clk);
        start = 1'b1; min = m; sub = s; preB = b;
        @(negedge clk);
        lat = 0;
        chk("busy_after_accept", busy, 1'b1);
        start = 1'b0;
        min   = 8'($urandom);
        sub   = 8'($urandom);
        preB  = 1'($urandom);
        while (!done && lat < 20) begin
            chk("diff_hold_while_busy", diff, exp_diff);
            chk("prob_hold_while_busy", proB, exp_prob);
            if (noisy) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, 8);
        chk("done_seen", done, 1'b1);
        chk("diff", diff, r[7:0]);
        chk("proB", proB, r[8]);
        exp_diff = r[7:0];
        exp_prob = r[8];
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_fall", busy, 1'b0);
        chk("diff_after_done", diff, exp_diff);
    endtask

    initial begin
        logic [7:0] dm [5];
        logic [7:0] ds [5];
        logic       db [5];
        int         rises [2];
        int         nr;
        logic       prev_busy;

        dm = '{8'h00, 8'h00, 8'h55, 8'hAA, 8'hFF};
        ds = '{8'h00, 8'h00, 8'hAA, 8'h55, 8'h00};
        db = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

        rst = 1'b1; start = 1'b1; min = 8'hA5; sub = 8'h5A; preB = 1'b1;
        exp_diff = 8'h00; exp_prob = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_proB", proB, 1'b0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("no_accept_from_reset", busy, 1'b0);

        for (int i = 0; i < 5; i++) run_op(dm[i], ds[i], db[i], 1'b0);

        run_op(8'h3C, 8'hC3, 1'b0, 1'b1);

        // Continuous start: acceptances spaced WIDTH+2 cycles apart.
        @(negedge clk);
        start = 1'b1; min = 8'h0F; sub = 8'h01; preB = 1'b0;
        nr = 0; prev_busy = busy;
        for (int i = 0; i < 40 && nr < 2; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                rises[nr] = cyc;
                nr++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        chk("hold_start_acceptances", nr, 2);
        if (nr == 2) chk("hold_start_period", rises[1] - rises[0], 10);
        for (int i = 0; i < 15 && busy; i++) @(negedge clk);
        chk("hold_start_idle", busy, 1'b0);
        chk("hold_start_diff", diff, 8'h0E);
        chk("hold_start_proB", proB, 1'b0);
        exp_diff = 8'h0E; exp_prob = 1'b0;

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; min = 8'h12; sub = 8'h34; preB = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midop_busy_before_rst", busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("midop_rst_busy", busy, 1'b0);
        chk("midop_rst_done", done, 1'b0);
        chk("midop_rst_diff", diff, 8'h00);
        chk("midop_rst_proB", proB, 1'b0);
        exp_diff = 8'h00; exp_prob = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h34, 8'h12, 1'b0, 1'b0);
        chk("after_rst_diff_22", exp_diff, 8'h22);

        for (int i = 0; i < 500; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), (i % 4) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/subtractor_serial_8bit.md
# subtractor_serial_8bit

Bit-serial 8-bit subtractor with borrow-in and borrow-out, the counterpart to the team's combinational 8-bit ripple full adder. It computes minuend minus subtrahend minus borrow-in, one bit per clock, LSB first. A start/done handshake wraps the computation. The block sits beside the adder in the arithmetic library, as the area-lean subtract path for multi-cycle datapaths.

## Interface
- WIDTH, 8, operand and result width in bits; must be at least 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin an operation; sampled only in IDLE.
- min  input  WIDTH  minuend; captured on the accepting edge.
- sub  input  WIDTH  subtrahend; captured on the accepting edge.
- preB  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; diff and proB are valid and newly updated.
- diff  output  WIDTH  result register, min − sub − preB mod 2^WIDTH.
- proB  output  1  borrow-out; 1 iff min < sub + preB, unsigned.

## Operation
- Datapath registers:
  - A and B: operand shift registers, shifted right each SHIFT cycle.
  - b: borrow flip-flop, loaded with preB.
  - D: result shift register; the new bit enters at the MSB, so after WIDTH shifts D holds the result in order.
  - cnt: bit counter, ceil(log2(WIDTH+1)) bits.
- Per-bit rule, with a=A[0], s=B[0], b=borrow: d = a^s^b; b_next = (~a&s) | (~a&b) | (s&b).
- State machine:
  - IDLE: if start, load A=min, B=sub, b=preB, cnt=0, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: process one bit per cycle and increment cnt. After the WIDTH-th bit (cnt==WIDTH−1 at that edge), go to DONE, load diff with the completed result including the final bit, and load proB with b_next.
  - DONE: done=1, then go to IDLE on the next edge unconditionally.
- start is ignored outside IDLE. There is no queuing and no error flag.
- min, sub and preB may change freely after the accepting edge; only the captured values are used.
- diff and proB change only on the SHIFT→DONE edge. They hold the previous result while busy.
- Reset (any time, including mid-SHIFT or during DONE) forces all of the following immediately, and any in-flight operation is discarded:
  - state=IDLE, busy=0, done=0
  - diff=0, proB=0
  - A, B, b, D, cnt all 0
- start asserted together with or during reset is not accepted. The first acceptance is the first rising edge with rst low and start high.

## Timing
- Reset values: busy=0, done=0, diff=0, proB=0.
- Edge E0: start seen high in IDLE.
- busy rises after E0 and stays high for WIDTH+1 cycles: WIDTH SHIFT cycles plus 1 DONE cycle.
- diff, proB and done update after edge E0+WIDTH. done is high for exactly one cycle, then falls after E0+WIDTH+1 together with busy.
- Latency from accepting edge to done is WIDTH cycles (8 at the default).
- Maximum throughput is one operation per WIDTH+2 cycles. Holding start high continuously gives acceptances at E0, E0+WIDTH+2, and so on.
- done and busy are registered outputs with no combinational path from the inputs.

## Test plan
- Reset, then start with min=0x00, sub=0x00, preB=0 -> done after 8 cycles; diff=0x00, proB=0.
- min=0x00, sub=0x00, preB=1 -> diff=0xFF, proB=1 (wrap-around).
- min=0x55, sub=0xAA, preB=1 -> diff=0xAA, proB=1.
- min=0xAA, sub=0x55, preB=0 -> diff=0x55, proB=0.
- min=0xFF, sub=0x00, preB=0 -> diff=0xFF, proB=0.
- Protocol checks:
  - Hold start high throughout: first acceptance at E0, next at E0+10.
  - Change min and sub mid-operation: no effect on the result.
  - Pulse start while busy: no effect.
  - diff and proB stay unchanged until done.
- Reset mid-op: assert rst 4 cycles after accepting min=0x12, sub=0x34 -> busy, done, diff and proB go to 0 immediately with no clock edge. After release, a new request min=0x34, sub=0x12 gives diff=0x22, proB=0 at the 8-cycle latency.
- Randomized sweep of 500 operands compared against the (WIDTH+1)-bit reference min − sub − preB -> exact match on every diff and proB.
